// File: rtl/alu_seq_param.sv
// Parametrised sequential ALU: add/and/or/gt/lt/shl in one cycle, shift-add mul and restoring div iteratively.
// Latency: single-cycle ops show out_valid after the accept edge; mul/div after WIDTH further edges.
// Backpressure: in_ready only in IDLE; while out_ready is low the result and flags hold in DONE.
module alu_seq_param #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     d_in_1,
   input  logic [WIDTH-1:0]     d_in_2,
   input  logic [2:0]           alu_op,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   d_out,
   output logic                 z_flag,
   output logic                 a_grt_b,
   output logic                 b_grt_a,
   output logic                 div_zero
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_MUL = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_DIV = 3'b100;
   localparam logic [2:0] OP_GT  = 3'b101;
   localparam logic [2:0] OP_LT  = 3'b110;
   localparam logic [2:0] OP_SHL = 3'b111;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_BUSY = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   localparam int             CW      = $clog2(WIDTH);
   localparam logic [CW-1:0]  LP_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  LP_ONE  = {{(CW-1){1'b0}}, 1'b1};

   logic [1:0]          r_state;
   logic [2:0]          r_op;
   logic [WIDTH-1:0]    r_a;
   logic [WIDTH-1:0]    r_b;
   logic [CW-1:0]       r_cnt;
   // Iteration pair: mul keeps {partial product high, multiplier/product low};
   // div keeps {partial remainder, dividend shifting out / quotient shifting in}.
   logic [WIDTH-1:0]    r_hi;
   logic [WIDTH-1:0]    r_lo;
   logic [2*WIDTH-1:0]  r_dout;
   logic                r_z;
   logic                r_gt;
   logic                r_lt;
   logic                r_div_zero;

   logic [WIDTH-1:0]    w_add_a;
   logic [WIDTH:0]      w_sum;
   logic [WIDTH:0]      w_trial;
   logic [WIDTH-1:0]    w_hi_nxt;
   logic [WIDTH-1:0]    w_lo_nxt;
   logic [WIDTH:0]      w_add;
   logic [WIDTH-1:0]    w_shl;
   logic [2*WIDTH-1:0]  w_res1;
   logic [WIDTH-1:0]    w_fa;
   logic [WIDTH-1:0]    w_fb;
   logic                w_accept;
   logic                w_multi;

   assign w_accept = in_valid && (r_state == ST_IDLE);
   assign w_multi  = (alu_op == OP_MUL) || (alu_op == OP_DIV);

   // One iteration step of shift-add multiply or restoring divide
   always_comb begin
      w_add_a  = r_lo[0] ? r_a : '0;
      w_sum    = {1'b0, r_hi} + {1'b0, w_add_a};
      // Minuend is < 2*divisor, so bit WIDTH of the difference is a clean borrow flag
      w_trial  = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_b};
      w_hi_nxt = r_hi;
      w_lo_nxt = r_lo;
      if (r_op == OP_MUL) begin
         w_hi_nxt = w_sum[WIDTH:1];
         w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
      end else if (!w_trial[WIDTH]) begin
         w_hi_nxt = w_trial[WIDTH-1:0];
         w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
         w_hi_nxt = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
         w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
      end
   end

   // Single-cycle results straight from the inputs, captured on the accept edge
   always_comb begin
      w_add  = {1'b0, d_in_1} + {1'b0, d_in_2};
      // A shift amount of WIDTH or more shifts every bit out, giving zero
      w_shl  = d_in_1 << d_in_2;
      w_res1 = '0;
      case (alu_op)
         OP_ADD:  w_res1 = {{(WIDTH-1){1'b0}}, w_add};
         OP_AND:  w_res1 = {{WIDTH{1'b0}}, d_in_1 & d_in_2};
         OP_OR:   w_res1 = {{WIDTH{1'b0}}, d_in_1 | d_in_2};
         OP_GT:   w_res1 = {{(2*WIDTH-1){1'b0}}, (d_in_1 > d_in_2)};
         OP_LT:   w_res1 = {{(2*WIDTH-1){1'b0}}, (d_in_1 < d_in_2)};
         OP_SHL:  w_res1 = {{WIDTH{1'b0}}, w_shl};
         default: w_res1 = '0;
      endcase
   end

   // Compare flags come from the live inputs on accept, from latched operands at the end of BUSY
   always_comb begin
      w_fa = (r_state == ST_IDLE) ? d_in_1 : r_a;
      w_fb = (r_state == ST_IDLE) ? d_in_2 : r_b;
   end

   // Control FSM and result/flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_op       <= OP_ADD;
         r_a        <= '0;
         r_b        <= '0;
         r_cnt      <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_dout     <= '0;
         r_z        <= 1'b0;
         r_gt       <= 1'b0;
         r_lt       <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_a        <= d_in_1;
                  r_b        <= d_in_2;
                  r_op       <= alu_op;
                  r_cnt      <= '0;
                  r_div_zero <= 1'b0;
                  if (w_multi) begin
                     r_hi    <= '0;
                     r_lo    <= (alu_op == OP_MUL) ? d_in_2 : d_in_1;
                     r_state <= ST_BUSY;
                  end else begin
                     r_dout  <= w_res1;
                     r_z     <= (w_fa == w_fb);
                     r_gt    <= (w_fa >  w_fb);
                     r_lt    <= (w_fa <  w_fb);
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_BUSY: begin
               r_hi  <= w_hi_nxt;
               r_lo  <= w_lo_nxt;
               r_cnt <= r_cnt + LP_ONE;
               if (r_cnt == LP_LAST) begin
                  // Both mul and div leave {high half, low half} in the result order we publish
                  r_dout     <= {w_hi_nxt, w_lo_nxt};
                  r_z        <= (w_fa == w_fb);
                  r_gt       <= (w_fa >  w_fb);
                  r_lt       <= (w_fa <  w_fb);
                  r_div_zero <= (r_op == OP_DIV) && (r_b == '0);
                  r_state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign d_out     = r_dout;
   assign z_flag    = r_z;
   assign a_grt_b   = r_gt;
   assign b_grt_a   = r_lt;
   assign div_zero  = r_div_zero;

endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
- Parametrised, clocked successor to the team's 16-bit combinational ALU.
- Width is generic. Operands arrive on a valid/ready handshake and results leave on one, so the ALU can sit between pipeline stages.
- Multiply runs as an iterative shift-add and divide as a restoring divide. This replaces the fixed divide-by-2 with a true quotient and remainder.
- All outputs are registered, including the compare flags and a divide-by-zero flag.

Parameters:
- WIDTH, 16, operand width in bits; must be >= 4. d_out is 2*WIDTH bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept; high only in IDLE
- d_in_1  in  WIDTH  operand A
- d_in_2  in  WIDTH  operand B
- alu_op  in  3  000 add, 001 mul, 010 and, 011 or, 100 div, 101 gt, 110 lt, 111 shl
- out_valid  out  1  result registers valid
- out_ready  in  1  consumer accepts result
- d_out  out  2*WIDTH  result
- z_flag  out  1  A == B for the accepted operands
- a_grt_b  out  1  A > B, unsigned
- b_grt_a  out  1  A < B, unsigned
- div_zero  out  1  last op was div with B == 0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0.
  - d_out=0; z_flag=0; a_grt_b=0; b_grt_a=0; div_zero=0; internal counters cleared.
  - Reset asserted mid-BUSY aborts the operation; no result is produced.
- Handshake:
  - Accept occurs on a rising edge with in_valid & in_ready.
  - Operands and op are latched on accept; input changes after accept have no effect.
  - The result is consumed on an edge with out_valid & out_ready.
- FSM states:
  - IDLE -> DONE on accept of a single-cycle op (add, and, or, gt, lt, shl).
  - IDLE -> BUSY on accept of mul or div.
  - BUSY -> DONE after exactly WIDTH iteration cycles.
  - DONE -> IDLE on out_ready.
  - in_ready is 0 in BUSY and DONE.
- Latency:
  - Single-cycle ops: out_valid high on the 1st edge after accept.
  - mul/div: out_valid high on edge WIDTH+1 after accept.
- Backpressure: in DONE with out_ready=0, d_out and all flags hold stable indefinitely.
- Flags:
  - z_flag, a_grt_b and b_grt_a are computed from the latched operands for every op, and update together with d_out.
  - Exactly one of the three is 1 whenever out_valid=1.
  - div_zero is cleared on every accept.
- Arithmetic (all unsigned, results zero-extended to 2*WIDTH):
  - add: A+B in WIDTH+1 bits; carry lands in d_out[WIDTH].
  - mul: full 2*WIDTH product.
  - and/or: bitwise.
  - gt/lt: d_out[0]=compare result; all other bits 0.
  - shl: A << B in WIDTH bits; if B >= WIDTH, result is 0.
  - div: d_out[WIDTH-1:0]=quotient; d_out[2*WIDTH-1:WIDTH]=remainder.
  - div with B=0: quotient all ones, remainder = A, div_zero=1. Still takes WIDTH cycles, so latency is uniform.
- Undefined op encodings: none; all 8 codes are defined.

Test Plan (WIDTH=16):
- add: A=0xFFFF, B=0x0001, op 000 -> d_out=0x00010000 one edge after accept; a_grt_b=1, z_flag=0.
- mul: A=300, B=500, op 001 -> in_ready low for 17 edges; out_valid at edge 17; d_out=0x000249F0.
- div: A=1000, B=7, op 100 -> d_out=0x0006008E (remainder 6, quotient 142); div_zero=0.
- div by zero: A=1234, B=0 -> d_out=0x04D2FFFF; div_zero=1; latency 17 edges.
- compare and shift:
  - A=5, B=9, op 110 -> d_out=1, b_grt_a=1.
  - A=B=0x0042, op 111 -> d_out=0, z_flag=1.
- backpressure/reset:
  - Hold out_ready=0 for 10 cycles after an and of 0xF0F0 & 0x0FF0 -> d_out stays 0x00F0, in_ready stays 0.
  - Drop rst_n during mul BUSY -> all outputs return to reset values immediately; out_valid never asserts for the aborted op.
